// File: rtl/md_pkg.sv
// md_pkg: md_op encoding and default multiply/divide latencies shared by
// the md_unit, the controller and the hazard unit.
package md_pkg;
    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6
    } md_op_e;

    localparam int MD_MULT_CYCLES = 5;
    localparam int MD_DIV_CYCLES  = 10;

    function automatic logic md_is_multicycle(input logic [2:0] op);
        return op >= MD_MULT && op <= MD_DIVU;
    endfunction
endpackage

// File: rtl/md_unit.sv
// md_unit: MIPS HI/LO multiply/divide unit; results are computed at start,
// held in a result latch and committed when the fixed-latency countdown ends.
module md_unit
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYCLES,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs_e,
    input  logic [31:0] rt_e,
    output logic        busy,
    output logic        stall_req,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam int MAXC = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [63:0]   res_q, res_d;
    logic          wr_q, wr_d;
    logic [31:0]   hi_q, hi_d, lo_q, lo_d;
    logic          accept, dz, is_mul, is_div;
    logic [31:0]   dv_s, dv_u, quo_s, rem_s;
    logic [63:0]   prod;

    always_comb begin
        // the final busy cycle also accepts, so operations can run back-to-back
        accept = start && cnt_q <= CW'(1);
        is_mul = op == MD_MULT || op == MD_MULTU;
        is_div = op == MD_DIV || op == MD_DIVU;
        dz     = rt_e == '0;
        // INT_MIN / -1 divides by 1 instead, yielding lo=INT_MIN, hi=0 without overflow
        dv_s   = (dz || (rs_e == 32'h8000_0000 && rt_e == '1)) ? 32'd1 : rt_e;
        dv_u   = dz ? 32'd1 : rt_e;
        quo_s  = $signed(rs_e) / $signed(dv_s);
        rem_s  = $signed(rs_e) % $signed(dv_s);
        prod   = op == MD_MULT ? {{32{rs_e[31]}}, rs_e} * {{32{rt_e[31]}}, rt_e}
                               : {32'd0, rs_e} * {32'd0, rt_e};
        cnt_d  = cnt_q == '0 ? cnt_q : cnt_q - CW'(1);
        {hi_d, lo_d} = (cnt_q == CW'(1) && wr_q) ? res_q : {hi_q, lo_q};
        res_d  = res_q;
        wr_d   = wr_q;
        if (accept && is_mul) begin
            cnt_d = CW'(MULT_CYCLES);
            res_d = prod;
            wr_d  = 1'b1;
        end
        if (accept && is_div) begin
            cnt_d = CW'(DIV_CYCLES);
            res_d = op == MD_DIV ? {rem_s, quo_s} : {rs_e % dv_u, rs_e / dv_u};
            wr_d  = !dz;
        end
        if (accept && op == MD_MTHI) hi_d = rs_e;
        if (accept && op == MD_MTLO) lo_d = rs_e;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            res_q <= '0;
            wr_q  <= 1'b0;
            hi_q  <= '0;
            lo_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            res_q <= res_d;
            wr_q  <= wr_d;
            hi_q  <= hi_d;
            lo_q  <= lo_d;
        end
    end

    assign busy      = cnt_q != '0;
    assign stall_req = (start && md_is_multicycle(op)) || busy;
    assign hi        = hi_q;
    assign lo        = lo_q;
endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed stimulus with a scoreboard of expected HI/LO commits,
// checked by a monitor that follows the busy sequence.
module tb_md_unit;
    import md_pkg::*;

    typedef struct {
        int          len;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        b2b;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] rs_e = '0;
    logic [31:0] rt_e = '0;
    logic        busy, stall_req;
    logic [31:0] hi, lo;

    int   errors = 0;
    int   checks = 0;
    int   viol = 0;
    int   n = 0;
    logic act = 1'b0;
    exp_t cur;
    exp_t q[$];

    md_unit dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .rs_e(rs_e), .rt_e(rt_e),
        .busy(busy), .stall_req(stall_req), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, a, e);
        end
    endtask

    always @(negedge clk) begin
        if (!act) begin
            if (busy && q.size() > 0) begin
                cur = q.pop_front();
                n = 1;
                act = 1'b1;
            end
        end else begin
            n++;
            if (n == cur.len + 1) begin
                chk("commit_hi", hi, cur.hi);
                chk("commit_lo", lo, cur.lo);
                chk("busy_after", {31'd0, busy}, {31'd0, cur.b2b});
                if (busy && q.size() > 0) begin
                    cur = q.pop_front();
                    n = 1;
                end else act = 1'b0;
            end else if (!busy) chk("busy_run", {31'd0, busy}, 32'd1);
        end
    end

    // start while busy (other than on the final busy cycle) is illegal
    always @(posedge clk) if (!reset && start && act && n < cur.len) viol++;

    task automatic go(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk) #2;
        start = 1'b1; op = o; rs_e = a; rt_e = b;
        @(posedge clk) #2;
        start = 1'b0; op = 3'd0; rs_e = $urandom; rt_e = $urandom;
    endtask

    task automatic push(input int len, input logic [31:0] h, input logic [31:0] l, input logic b);
        exp_t e;
        e.len = len; e.hi = h; e.lo = l; e.b2b = b;
        q.push_back(e);
    endtask

    task automatic drain;
        int k = 0;
        while ((q.size() > 0 || act) && k < 60) begin
            @(negedge clk);
            k++;
        end
        if (k >= 60) begin
            errors++;
            checks++;
            $display("FAIL drain_timeout: got pending=%0d expected 0", q.size());
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $finish;
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_stall", {31'd0, stall_req}, 32'd0);
        @(posedge clk) #2;
        start = 1'b1; op = MD_DIVU;
        #1 chk("stall_comb_div", {31'd0, stall_req}, 32'd1);
        op = MD_MTLO;
        #1 chk("stall_comb_mtlo", {31'd0, stall_req}, 32'd0);
        start = 1'b0; op = 3'd0;

        go(MD_MTHI, 32'h55, 32'h0);
        @(negedge clk) chk("mthi", hi, 32'h55);
        go(MD_MULT, 32'd3, 32'd4);
        @(posedge clk) #2 reset = 1'b1;
        @(posedge clk) #2 reset = 1'b0;
        @(negedge clk);
        chk("rstmid_hi", hi, 32'd0);
        chk("rstmid_lo", lo, 32'd0);
        chk("rstmid_busy", {31'd0, busy}, 32'd0);
        repeat (6) @(negedge clk);
        chk("rstmid_nocommit", lo, 32'd0);

        push(5, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0);
        go(MD_MULT, 32'hFFFF_FFFE, 32'd3);
        @(negedge clk) chk("stall_busy", {31'd0, stall_req}, 32'd1);
        drain();
        push(5, 32'h0000_0002, 32'hFFFF_FFFA, 1'b0);
        go(MD_MULTU, 32'hFFFF_FFFE, 32'd3);
        drain();
        push(10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        go(MD_DIV, 32'hFFFF_FFF9, 32'd2);
        drain();
        push(10, 32'd1, 32'd3, 1'b0);
        go(MD_DIVU, 32'd7, 32'd2);
        drain();
        push(10, 32'd0, 32'h8000_0000, 1'b0);
        go(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        drain();

        go(MD_MTHI, 32'h11, 32'h0);
        go(MD_MTLO, 32'h22, 32'h0);
        @(negedge clk) chk("mtlo", lo, 32'h22);
        push(10, 32'h11, 32'h22, 1'b0);
        go(MD_DIVU, 32'h1234, 32'd0);
        drain();

        push(5, 32'd0, 32'd7, 1'b0);
        go(MD_MULT, 32'd1, 32'd7);
        @(posedge clk) #2;
        start = 1'b1; op = MD_MTHI; rs_e = 32'h99;
        @(posedge clk) #2;
        start = 1'b0; op = 3'd0;
        @(negedge clk) chk("mthi_ignored", hi, 32'h11);
        drain();

        push(5, 32'd0, 32'd6, 1'b1);
        push(5, 32'd0, 32'd25, 1'b0);
        @(posedge clk) #2;
        start = 1'b1; op = MD_MULT; rs_e = 32'd2; rt_e = 32'd3;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk) #2;
            start = 1'b0; op = 3'd0; rs_e = $urandom; rt_e = $urandom;
        end
        @(posedge clk) #2;
        start = 1'b1; op = MD_MULTU; rs_e = 32'd5; rt_e = 32'd5;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk) #2;
            start = 1'b0; op = 3'd0; rs_e = $urandom; rt_e = $urandom;
        end
        drain();

        chk("assert_flagged", viol, 32'd1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/md_unit.md
# md_unit

Multiply/divide unit for the E stage of the 5-stage MIPS pipeline. It consumes the operand and instruction fields latched by the D/E pipeline register and executes mult/multu/div/divu with a fixed multi-cycle latency. It holds the HI/LO registers, serves mthi/mtlo writes and supplies mfhi/mflo read data. A busy flag lets the hazard unit stall the D stage.

## Interface
Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (≥1)
- DIV_CYCLES, 10, busy cycles for div/divu (≥1)

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  E-stage instruction is a md-class op; qualifies op
- op  in  3  md_op code (md_pkg): NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6
- rs_e  in  32  forwarded rs operand (dividend / multiplicand / mthi-mtlo source)
- rt_e  in  32  forwarded rt operand (divisor / multiplier)
- busy  out  1  multi-cycle operation in progress
- stall_req  out  1  combinational start_is_multicycle | busy; hazard unit stalls any md-class instruction in D on this
- hi  out  32  HI register
- lo  out  32  LO register

## Operation
- Reset: hi=0, lo=0, busy=0, internal counter=0, result latches=0. Reset has priority over everything, including an operation in flight, which is abandoned with no HI/LO update.
- Idle (busy=0) and start=1:
  - MULT: computes {hi,lo} result = signed 64-bit rs_e*rt_e. Counter loads MULT_CYCLES.
  - MULTU: same, unsigned.
  - DIV: lo = rs_e/rt_e signed, truncating toward zero; hi = remainder, sign of dividend. Counter loads DIV_CYCLES.
  - DIVU: same, unsigned.
  - MTHI: hi <= rs_e on that edge, no busy. MTLO: lo <= rs_e, no busy.
  - NONE or codes 7: no effect.
- Operands are captured at the start edge. Later changes to rs_e/rt_e do not affect the result.
- Divide by zero (rt_e=0, DIV/DIVU): busy sequence runs normally; hi/lo are left unchanged at completion.
- Signed overflow case 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- start=1 while busy=1: ignored entirely, including MTHI/MTLO. The hazard unit guarantees this never occurs; the verification bench checks it with an assertion.
- States: IDLE (counter=0) and RUN (counter>0). busy = (counter != 0). On each edge in RUN the counter decrements. On the 1→0 transition the latched result is committed to hi/lo.

## Timing
- Start sampled at edge E0. busy=1 during the cycles following E0, E1…E(N-1) inclusive, for N = MULT_CYCLES or DIV_CYCLES. busy is high for exactly N cycles.
- hi/lo take the new value at edge EN, the same edge at which busy falls. A start may be accepted at EN, giving back-to-back operations with no idle bubble.
- MTHI/MTLO: value visible on hi/lo from the cycle after E0.
- hi/lo outputs are registers with no combinational path from the inputs. stall_req is combinational from start/op.

## Structure
- Shared package md_pkg holds the md_op encoding constants and default latency constants. The controller and hazard unit import it too.
- Single module. No sub-module: the * and / operators are behavioural, latched into a 64-bit result register at start. The counter and commit logic are inline.

## Test plan
- Reset mid-op: start MULT 3×4, then assert reset at E2 → hi=0, lo=0, busy=0 at the next cycle; no commit afterwards.
- MULT signed: rs=0xFFFFFFFE (−2), rt=3 → busy high 5 cycles; at E5 hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULTU on the same operands → hi=0x00000002, lo=0xFFFFFFFA.
- DIV signed: rs=−7 (0xFFFFFFF9), rt=2 → busy high 10 cycles; lo=0xFFFFFFFD (−3), hi=0xFFFFFFFF (−1). DIVU 7/2 → lo=3, hi=1.
- Divide by zero: preload hi=0x11, lo=0x22 via MTHI/MTLO, then DIVU x/0 → busy 10 cycles; hi=0x11, lo=0x22 unchanged.
- Operand change during RUN and back-to-back: start MULT 2×3, change rs_e/rt_e every cycle, issue MULTU 5×5 at E5 → first result lo=6, then lo=25 exactly 5 cycles later; busy never drops between the two operations.
- MTHI/MTLO and ignored start: MTLO 0xABCD at idle → lo=0xABCD next cycle. MTHI issued while busy → hi unchanged and assertion flagged.
